// File: rtl/msx_mem_pkg.sv
// msx_mem_pkg: shared types and constants for the MSX memory arbiter
package msx_mem_pkg;
  localparam int ADDR_W = 27;
  localparam logic [7:0] IDLE_DATA = 8'hFF;
  typedef enum logic [1:0] {IDLE, CPU_ACC, FLASH_ACC, FLASH_END} arb_state_t;
endpackage

// File: rtl/arb_timeout.sv
// arb_timeout: per-access cycle counter that flags an SDRAM access that has waited TIMEOUT cycles
module arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else r_cnt <= clr ? 8'd0 : en ? r_cnt + 8'd1 : r_cnt;
  // fires in the TIMEOUT-th waiting cycle so sdr_req is high exactly TIMEOUT cycles
  assign expired = en & (r_cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/msx_mem_arbiter.sv
// msx_mem_arbiter: merges CPU slot cycles and flash-emulation writes onto one SDRAM req/ack port
module msx_mem_arbiter
  import msx_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_din,
  input  logic              ram_rnw,
  input  logic              sdram_ce,
  output logic [7:0]        ram_dout,
  output logic              cpu_wait,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic [7:0]        flash_din,
  input  logic              flash_req,
  output logic              flash_ready,
  output logic              flash_done,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [7:0]        sdr_din,
  output logic              sdr_we,
  output logic              sdr_req,
  input  logic              sdr_ack,
  input  logic [7:0]        sdr_dout,
  output logic              timeout_err
);
  arb_state_t        r_state;
  logic              r_served;
  logic [ADDR_W-1:0] r_cpu_addr;
  logic              w_new_cpu, w_idle, w_in_acc, w_expired, w_end;
  // a held sdram_ce on an already-served address is the same Z80 cycle, not a new access
  assign w_new_cpu   = sdram_ce & (~r_served | (ram_addr != r_cpu_addr));
  assign w_idle      = r_state == IDLE;
  assign w_in_acc    = (r_state == CPU_ACC) | (r_state == FLASH_ACC);
  assign w_end       = sdr_ack | w_expired;
  assign cpu_wait    = w_new_cpu | (r_state == CPU_ACC);
  assign flash_ready = w_idle & ~w_new_cpu;
  arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_idle & (w_new_cpu | flash_req)),
    .en     (w_in_acc),
    .expired(w_expired)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_served    <= 1'b0;
      r_cpu_addr  <= '0;
      ram_dout    <= IDLE_DATA;
      sdr_addr    <= '0;
      sdr_din     <= '0;
      sdr_we      <= 1'b0;
      sdr_req     <= 1'b0;
      flash_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      flash_done <= 1'b0;
      if (!sdram_ce) r_served <= 1'b0;
      case (r_state)
        IDLE:
          if (w_new_cpu) begin
            r_cpu_addr <= ram_addr;
            sdr_addr   <= ram_addr;
            sdr_din    <= ram_din;
            sdr_we     <= ~ram_rnw;
            sdr_req    <= 1'b1;
            r_state    <= CPU_ACC;
          end else if (flash_req) begin
            sdr_addr <= flash_addr;
            sdr_din  <= flash_din;
            sdr_we   <= 1'b1;
            sdr_req  <= 1'b1;
            r_state  <= FLASH_ACC;
          end
        CPU_ACC:
          if (w_end) begin
            sdr_req     <= 1'b0;
            r_served    <= 1'b1;
            ram_dout    <= sdr_we ? ram_dout : sdr_ack ? sdr_dout : IDLE_DATA;
            timeout_err <= timeout_err | ~sdr_ack;
            r_state     <= IDLE;
          end
        FLASH_ACC:
          if (w_end) begin
            sdr_req     <= 1'b0;
            flash_done  <= 1'b1;
            timeout_err <= timeout_err | ~sdr_ack;
            r_state     <= FLASH_END;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
